// File: rtl/multicycle_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback, drives datapath controls and counts retired instructions.
module multicycle_main_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             Branch,
    output logic             PCWrite,
    output logic             PCEn,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t           st, nxt;
    logic             retire;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            st <= nxt;
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nxt        = FETCH;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (st)
            FETCH:   nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_RTYP:      nxt = RTYPEEX;
                    OP_BEQ:       nxt = BEQEX;
                    OP_ADDI:      nxt = ADDIEX;
                    OP_J:         nxt = JEX;
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR: begin
                nxt    = mem_ready ? FETCH : MEMWR;
                retire = mem_ready;
            end
            RTYPEEX: nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BEQEX, JEX: begin
                nxt    = FETCH;
                retire = 1'b1;
            end
            default: nxt = FETCH;
        endcase
    end

    // Moore decode; FETCH enables are qualified by mem_ready so a stall writes nothing.
    always_comb begin
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        Branch   = 1'b0;
        PCWrite  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        case (st)
            FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BEQEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                Branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:  RegWrite = 1'b1;
            JEX: begin
                PCSrc   = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCEn        = PCWrite | (Branch & zero);
    assign state       = st;
    assign instr_count = cnt;

endmodule
